// File: rtl/rr_dec_sel.sv
// rr_dec_sel: round-robin arbiter that drives the select and enable inputs of a
// 2-to-4 decoder. It holds each grant until done, withdrawal or hold timeout,
// then inserts one enable-low gap cycle before arbitrating again.
module rr_dec_sel #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] in,
  output logic       enable,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [1:0]       in_q, in_d;
  logic [1:0]       last_q, last_d;
  logic             en_q, en_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // First set request bit, searching cyclically from last+1 so the most
  // recently granted channel has the lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  logic       rel_normal;  // done or withdraw: release without timeout
  logic       rel_force;   // hold limit reached with the requester still active
  logic [1:0] pick;

  assign rel_normal = done || !req[in_q];
  assign rel_force  = (cnt_q == TO_VAL) && !rel_normal;
  assign pick       = rr_pick(req, last_q);

  // Next-state and next-output decode; every output is registered.
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    last_d  = last_q;
    en_d    = en_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d = GRANT;
          in_d    = pick;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel_normal || rel_force) begin
          // done/withdraw win over the timeout when they coincide
          state_d = GAP;
          last_d  = in_q;
          en_d    = 1'b0;
          cnt_d   = '0;
          to_d    = rel_force;
        end else if (cnt_q != TO_VAL) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        // single all-zero decoder cycle; in keeps the old index
        state_d = IDLE;
        en_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears enable without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      in_q    <= 2'b00;
      last_q  <= 2'b11;
      en_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      last_q  <= last_d;
      en_q    <= en_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in      = in_q;
  assign enable  = en_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_dec_sel.sv
// Directed bench for rr_dec_sel with TIMEOUT=8.
module tb_rr_dec_sel;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [1:0] in;
  logic       enable;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  rr_dec_sel #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .in(in), .enable(enable), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge and sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    step();
    step();
    chk("rst_in", 8'(in), 8'h0);
    chk("rst_en", 8'(enable), 8'h0);
    chk("rst_to", 8'(timeout), 8'h0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;

    // 1: single requester, done in 3rd grant cycle, re-grant
    do_reset();
    req = 4'b0001;
    step();
    chk("t1_c1_en", 8'(enable), 8'h1);
    chk("t1_c1_in", 8'(in), 8'h0);
    step();
    chk("t1_c2_en", 8'(enable), 8'h1);
    step();
    chk("t1_c3_en", 8'(enable), 8'h1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t1_gap_en", 8'(enable), 8'h0);
    chk("t1_gap_to", 8'(timeout), 8'h0);
    chk("t1_gap_in", 8'(in), 8'h0);
    step();
    chk("t1_idle_en", 8'(enable), 8'h0);
    step();
    chk("t1_regrant_en", 8'(enable), 8'h1);
    chk("t1_regrant_in", 8'(in), 8'h0);
    chk("t1_regrant_to", 8'(timeout), 8'h0);

    // 2: all requesting, done every 2nd grant cycle -> 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      chk("t2_c1_en", 8'(enable), 8'h1);
      chk("t2_c1_in", 8'(in), 8'(g % 4));
      step();
      chk("t2_c2_en", 8'(enable), 8'h1);
      chk("t2_c2_in", 8'(in), 8'(g % 4));
      done = 1'b1;
      step();
      done = 1'b0;
      chk("t2_gap_en", 8'(enable), 8'h0);
      step();
      chk("t2_idle_en", 8'(enable), 8'h0);
    end

    // 3: no done -> exactly 8 enable cycles, timeout pulse in gap
    do_reset();
    req = 4'b0100;
    step();
    for (int i = 1; i <= 8; i++) begin
      chk("t3_hold_en", 8'(enable), 8'h1);
      chk("t3_hold_in", 8'(in), 8'h2);
      chk("t3_hold_to", 8'(timeout), 8'h0);
      step();
    end
    chk("t3_gap_en", 8'(enable), 8'h0);
    chk("t3_gap_to", 8'(timeout), 8'h1);
    step();
    chk("t3_idle_to", 8'(timeout), 8'h0);
    chk("t3_idle_en", 8'(enable), 8'h0);
    step();
    chk("t3_regrant_en", 8'(enable), 8'h1);
    chk("t3_regrant_in", 8'(in), 8'h2);

    // 4: make last=1, then req=1010 -> 3,1,3
    do_reset();
    req = 4'b0010;
    step();
    chk("t4_pre_in", 8'(in), 8'h1);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b1010;
    step();
    step();
    chk("t4_g1_en", 8'(enable), 8'h1);
    chk("t4_g1_in", 8'(in), 8'h3);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    step();
    chk("t4_g2_in", 8'(in), 8'h1);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    step();
    chk("t4_g3_en", 8'(enable), 8'h1);
    chk("t4_g3_in", 8'(in), 8'h3);

    // 5: async reset mid-grant at counter=4
    do_reset();
    req = 4'b0100;
    step();
    step();
    step();
    step();
    chk("t5_pre_en", 8'(enable), 8'h1);
    chk("t5_pre_in", 8'(in), 8'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_en", 8'(enable), 8'h0);
    chk("t5_async_in", 8'(in), 8'h0);
    step();
    reset = 1'b0;
    step();
    chk("t5_post_en", 8'(enable), 8'h1);
    chk("t5_post_in", 8'(in), 8'h2);

    // 6: done coincides with counter==TIMEOUT -> no timeout pulse
    do_reset();
    req = 4'b0001;
    step();
    for (int i = 1; i <= 7; i++) begin
      chk("t6_hold_en", 8'(enable), 8'h1);
      step();
    end
    chk("t6_c8_en", 8'(enable), 8'h1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t6_gap_en", 8'(enable), 8'h0);
    chk("t6_gap_to", 8'(timeout), 8'h0);
    step();
    chk("t6_idle_en", 8'(enable), 8'h0);
    step();
    chk("t6_regrant_en", 8'(enable), 8'h1);

    // withdraw coinciding with counter==TIMEOUT also suppresses timeout
    for (int i = 1; i <= 7; i++) step();
    chk("t6w_c8_en", 8'(enable), 8'h1);
    req = 4'b0000;
    step();
    chk("t6w_gap_en", 8'(enable), 8'h0);
    chk("t6w_gap_to", 8'(timeout), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
